control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Multi-cycle hardwired control unit driving the 16-bit datapath's control word (DR/SA/SB/AX/BX/DX/FS/MB/MM/MD/MW + RW).
//  Fetches 16-bit instructions, decodes them, sequences multi-cycle ops through temp reg R8, and consumes datapath V/C/N/Z for branches.
//  Sits beside the datapath; owns the PC and the instruction-memory fetch handshake.
// PARAMETERS
//  nbit  16  datapath/PC width
//  IW    16  instruction width; format op[15:9] DR[8:6] SA[5:3] SB[2:0]
// PORTS
//  clk_main     in   1     single clock, all state updates on rising edge
//  reset        in   1     asynchronous, active-low; clears all state immediately
//  instr_in     in   IW    instruction word from instruction memory
//  instr_valid  in   1     instr_in valid this cycle
//  fetch_req    out  1     fetch request; pc_out held stable while high
//  pc_out       out  nbit  current PC
//  BusA         in   nbit  datapath A bus (JMP target)
//  V,C,N,Z      in   1     datapath ALU flags, combinational from current FS
//  DR,SA,SB     out  3     datapath register selects
//  AX,BX,DX     out  4     extended selects (bit3=1 -> temps R8..R15)
//  FS           out  4     function select
//  MB,MM,MD,MW  out  1     B-mux, addr-mux, dest-mux, memory write
//  RW           out  1     register-file write enable
//  halted       out  1     HLT executed
// BEHAVIOUR
//  Reset: PC=0, state=FETCH, IR=0, flags=0, cnt=0, halted=0; all control outputs 0 (RW=MW=0) while reset low.
//  States: FETCH, DECODE, EXEC, SH_LOAD, SH_LOOP, SH_STORE, HALT.
//  FETCH: fetch_req=1; on edge with instr_valid=1: IR<=instr_in, PC<=PC+1 (wraps 2^nbit-1->0), ->DECODE; else stay, PC held.
//  DECODE: 1 cycle, no writes. SRM/SLM ->SH_LOAD; HLT ->HALT; else ->EXEC.
//  EXEC (1 cycle, ->FETCH):
//   - ALU ops (op[6:4]=000, op!=SRM/SLM): FS=op[3:0], DX={0,DR}, AX={0,SA}, BX={0,SB}, RW=1, MB=MD=MM=MW=0; latch V,C,N,Z.
//   - LD: MD=1, MM=0, AX={0,SA}, DX={0,DR}, RW=1. ST: MW=1, MM=0, AX={0,SA}, BX={0,SB}, RW=0. Flags unchanged.
//   - BRZ/BRN: if latched Z/N=1: PC<=PC+sext({DR,SB}) (6-bit offset, PC already incremented, mod 2^nbit); else no change. RW=MW=0.
//   - JMP: AX={0,SA}, PC<=BusA.
//   - Unknown opcode: NOP (RW=MW=0), ->FETCH.
//  Shift SRM/SLM (amount k=SB, 0..7): SH_LOAD: R8<=R[SA] (AX={0,SA}, FS=0000, DX=8, RW=1), cnt<=k.
//   SH_LOOP: while cnt!=0: BX=8, FS=1101(SRM)/1110(SLM), DX=8, RW=1, cnt-=1; cnt==0 on entry -> SH_STORE with no write.
//   SH_STORE: R[DR]<=R8 (AX=8, FS=0000, DX={0,DR}, RW=1), latch flags, ->FETCH. Total cycles = 3+k after DECODE.
//  HALT: halted=1, fetch_req=0, RW=MW=0; exits only via reset.
//  Control outputs are combinational from (state, IR, cnt); outside EXEC/SH_* all selects 0, RW=MW=0.
//  Reset mid-op: async abort; partial shift leaves R8 only modified, never R[DR].
//  instr_valid while fetch_req=0: ignored.
// STRUCTURE
//  Package ctrl_pkg: opcode localparams (ALU 00000xx..0001100, SRM 0001101, SLM 0001110, LD 0010000, ST 0100000,
//   BRZ 1100000, BRN 1100001, JMP 1110000, HLT 1111111), FS encodings, state encodings, TEMP_R8=4'd8.
//  Sub-module ctrl_decode: combinational IR -> instruction class + field extraction; FSM, PC, cnt, flag latch in top.
// TESTING
//  Reset low mid-SH_LOOP -> all outputs 0 same cycle, PC=0, state FETCH after release; R[DR] never written.
//  Fetch stall: instr_valid low 3 cycles -> fetch_req high, pc_out constant, no PC change; valid on 4th -> PC 0->1.
//  ADD R3,R1,R2 (0000010_011_001_010) -> EXEC: FS=0010, DX=3, AX=1, BX=2, RW=1; flags latched.
//  SLM R4,R5,3 -> 6 cycles after DECODE: SH_LOAD, 3x FS=1110 DX=8, SH_STORE DX=4 AX=8 RW=1.
//  SUB giving Z=1 then BRZ offset 6'b111110 at PC=10 -> PC=9; with Z=0 -> PC=11.
//  HLT -> halted=1, fetch_req=0 indefinitely; PC=0xFFFF fetch -> PC wraps to 0x0000.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the hardwired control sequencer: opcodes, function selects,
// FSM states and the decoded-instruction record.
package ctrl_pkg;
   localparam logic [6:0] OP_SRM = 7'b0001101;
   localparam logic [6:0] OP_SLM = 7'b0001110;
   localparam logic [6:0] OP_LD  = 7'b0010000;
   localparam logic [6:0] OP_ST  = 7'b0100000;
   localparam logic [6:0] OP_BRZ = 7'b1100000;
   localparam logic [6:0] OP_BRN = 7'b1100001;
   localparam logic [6:0] OP_JMP = 7'b1110000;
   localparam logic [6:0] OP_HLT = 7'b1111111;

   localparam logic [3:0] FS_MOVA = 4'b0000;
   localparam logic [3:0] FS_SRM  = 4'b1101;
   localparam logic [3:0] FS_SLM  = 4'b1110;
   localparam logic [3:0] TEMP_R8 = 4'd8;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_SH_LOAD, S_SH_LOOP, S_SH_STORE, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      CL_NOP, CL_ALU, CL_SRM, CL_SLM, CL_LD, CL_ST, CL_BRZ, CL_BRN, CL_JMP, CL_HLT
   } iclass_t;

   typedef struct packed {
      iclass_t    cls;
      logic [2:0] dr;
      logic [2:0] sa;
      logic [2:0] sb;
      logic [3:0] fs;
      logic [5:0] off;
   } dec_t;

   // Widen a 3-bit architectural register select into the 4-bit extended space.
   function automatic logic [3:0] ext(input logic [2:0] r);
      return {1'b0, r};
   endfunction
endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: classifies the IR opcode and extracts the
// register fields and the 6-bit branch offset.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [15:0] ir,
   output dec_t        dec
);
   logic [6:0] op;
   assign op = ir[15:9];

   always_comb begin
      dec.dr  = ir[8:6];
      dec.sa  = ir[5:3];
      dec.sb  = ir[2:0];
      dec.fs  = op[3:0];
      dec.off = {ir[8:6], ir[2:0]};
      dec.cls = CL_NOP;
      case (op)
         OP_SRM:  dec.cls = CL_SRM;
         OP_SLM:  dec.cls = CL_SLM;
         OP_LD:   dec.cls = CL_LD;
         OP_ST:   dec.cls = CL_ST;
         OP_BRZ:  dec.cls = CL_BRZ;
         OP_BRN:  dec.cls = CL_BRN;
         OP_JMP:  dec.cls = CL_JMP;
         OP_HLT:  dec.cls = CL_HLT;
         default: if (op[6:4] == 3'b000) dec.cls = CL_ALU;
      endcase
   end
endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle hardwired control unit: owns PC/IR, sequences shifts through temp R8,
// and drives the datapath control word combinationally from (state, IR, cnt).
module control_sequencer
   import ctrl_pkg::*;
#(
   parameter int nbit = 16,
   parameter int IW   = 16
) (
   input  logic            clk_main,
   input  logic            reset,
   input  logic [IW-1:0]   instr_in,
   input  logic            instr_valid,
   output logic            fetch_req,
   output logic [nbit-1:0] pc_out,
   input  logic [nbit-1:0] BusA,
   input  logic            V,
   input  logic            C,
   input  logic            N,
   input  logic            Z,
   output logic [2:0]      DR,
   output logic [2:0]      SA,
   output logic [2:0]      SB,
   output logic [3:0]      AX,
   output logic [3:0]      BX,
   output logic [3:0]      DX,
   output logic [3:0]      FS,
   output logic            MB,
   output logic            MM,
   output logic            MD,
   output logic            MW,
   output logic            RW,
   output logic            halted
);
   state_t          state, nxt;
   logic [IW-1:0]   ir;
   logic [nbit-1:0] pc;
   logic [2:0]      cnt;
   logic [3:0]      flg;    // {V,C,N,Z} latched at ALU EXEC / SH_STORE
   dec_t            dec;

   ctrl_decode u_dec (.ir(ir), .dec(dec));

   always_ff @(posedge clk_main or negedge reset)
      if (!reset) state <= S_FETCH;
      else        state <= nxt;

   always_comb begin
      nxt = state;
      fetch_req = 1'b0;
      AX = 4'd0; BX = 4'd0; DX = 4'd0; FS = FS_MOVA;
      MB = 1'b0; MM = 1'b0; MD = 1'b0; MW = 1'b0; RW = 1'b0;
      case (state)
         S_FETCH: begin
            fetch_req = reset;
            if (instr_valid) nxt = S_DECODE;
         end
         S_DECODE: begin
            case (dec.cls)
               CL_SRM, CL_SLM: nxt = S_SH_LOAD;
               CL_HLT:         nxt = S_HALT;
               default:        nxt = S_EXEC;
            endcase
         end
         S_EXEC: begin
            nxt = S_FETCH;
            case (dec.cls)
               CL_ALU: begin
                  FS = dec.fs; DX = ext(dec.dr); AX = ext(dec.sa); BX = ext(dec.sb); RW = 1'b1;
               end
               CL_LD: begin
                  MD = 1'b1; AX = ext(dec.sa); DX = ext(dec.dr); RW = 1'b1;
               end
               CL_ST: begin
                  MW = 1'b1; AX = ext(dec.sa); BX = ext(dec.sb);
               end
               CL_JMP:  AX = ext(dec.sa);
               default: ;
            endcase
         end
         S_SH_LOAD: begin
            AX = ext(dec.sa); DX = TEMP_R8; RW = 1'b1;
            nxt = S_SH_LOOP;
         end
         S_SH_LOOP: begin
            // One idle pass with cnt==0 before the store keeps the k=0 case uniform.
            if (cnt != 3'd0) begin
               BX = TEMP_R8; DX = TEMP_R8; RW = 1'b1;
               FS = (dec.cls == CL_SRM) ? FS_SRM : FS_SLM;
            end else begin
               nxt = S_SH_STORE;
            end
         end
         S_SH_STORE: begin
            AX = TEMP_R8; DX = ext(dec.dr); RW = 1'b1;
            nxt = S_FETCH;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_main or negedge reset)
      if (!reset) begin
         pc  <= '0;
         ir  <= '0;
         cnt <= 3'd0;
         flg <= 4'd0;
      end else begin
         case (state)
            S_FETCH: if (instr_valid) begin
               ir <= instr_in;
               pc <= pc + 1'b1;
            end
            S_EXEC: begin
               case (dec.cls)
                  CL_ALU: flg <= {V, C, N, Z};
                  CL_BRZ: if (flg[0]) pc <= pc + {{(nbit-6){dec.off[5]}}, dec.off};
                  CL_BRN: if (flg[1]) pc <= pc + {{(nbit-6){dec.off[5]}}, dec.off};
                  CL_JMP: pc <= BusA;
                  default: ;
               endcase
            end
            S_SH_LOAD:  cnt <= dec.sb;
            S_SH_LOOP:  if (cnt != 3'd0) cnt <= cnt - 3'd1;
            S_SH_STORE: flg <= {V, C, N, Z};
            default: ;
         endcase
      end

   assign DR     = DX[2:0];
   assign SA     = AX[2:0];
   assign SB     = BX[2:0];
   assign pc_out = pc;
   assign halted = (state == S_HALT);
endmodule
